// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the supervisor state encoding and the shared-counter width calculation.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } sup_state_t;

  // Wide enough to hold the largest terminal count (value - 1) of any timed state.
  function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                   input int stable_cycles);
    int m;
    int w;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level input.
// Resets to 0 so a lock indication is never assumed out of reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Brings up the PLL: pulses its reset, qualifies lock, and releases the system reset.
// Retries on lock timeout, restarts on lock loss, and parks in FAULT after repeated timeouts.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  sup_state_t    state_r;
  sup_state_t    next_s;
  logic [CW-1:0] cnt_r;
  logic          lock_s;
  logic          lost_s;
  logic [3:0]    retry_next_s;
  logic [7:0]    loss_next_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state and counter-update decisions; lock has priority over timeout.
  always_comb begin
    next_s       = state_r;
    retry_next_s = retry_cnt;
    loss_next_s  = loss_cnt;
    lost_s       = 1'b0;
    case (state_r)
      RESET_PLL: begin
        if (cnt_r == RST_LAST) next_s = WAIT_LOCK;
        else                   next_s = RESET_PLL;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          next_s = STABILIZE;
        end else if (cnt_r == TMO_LAST) begin
          if (retry_cnt == RETRY_LIMIT) begin
            next_s = FAULT;
          end else begin
            next_s       = RESET_PLL;
            retry_next_s = retry_cnt + 4'd1;
          end
        end else begin
          next_s = WAIT_LOCK;
        end
      end
      STABILIZE: begin
        if (!lock_s)                next_s = WAIT_LOCK;
        else if (cnt_r == STB_LAST) next_s = RUN;
        else                        next_s = STABILIZE;
      end
      RUN: begin
        if (!lock_s) begin
          next_s       = RESET_PLL;
          lost_s       = 1'b1;
          retry_next_s = 4'd0;
          loss_next_s  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
        end else begin
          next_s = RUN;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          next_s       = RESET_PLL;
          retry_next_s = 4'd0;
        end else begin
          next_s = FAULT;
        end
      end
      default: begin
        next_s = RESET_PLL;
      end
    endcase
  end

  // Shared interval counter: cleared on every transition, idle in RUN and FAULT.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (next_s != state_r) begin
      cnt_r <= '0;
    end else if ((state_r == RESET_PLL) || (state_r == WAIT_LOCK) || (state_r == STABILIZE)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // State and outputs, decoded from the next state so they change on the entry edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RESET_PLL;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
    end else begin
      state_r   <= next_s;
      pll_rst   <= (next_s == RESET_PLL) || (next_s == FAULT);
      sys_rst_n <= (next_s == RUN);
      ready     <= (next_s == RUN);
      lock_lost <= lost_s;
      fault     <= (next_s == FAULT);
      retry_cnt <= retry_next_s;
      loss_cnt  <= loss_next_s;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: a vector table, directed corner sequences,
// and randomized lock behaviour, all compared every cycle against a phase/timer reference model.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;
  localparam int MR  = 2;
  localparam int SS  = 2;
  localparam logic [16:0] RESET_VEC = 17'h10000;

  localparam int PH_BOOT   = 0;
  localparam int PH_HUNT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_LIVE   = 3;
  localparam int PH_STUCK  = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       clear_fault = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  // Reference model: phase, time spent in phase, counters and a queue delaying the lock pin.
  int m_phase;
  int m_elapsed;
  int m_retries;
  int m_losses;
  bit m_lost;
  bit m_hist[$];

  typedef struct {
    int          cycles;
    bit          lk;
    bit          clr;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[11];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .MAX_RETRIES    (MR),
    .SYNC_STAGES    (SS)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .clear_fault (clear_fault),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt)
  );

  always #10 refclk = ~refclk;

  function automatic logic [16:0] mk(input logic pr, input logic sr, input logic rd,
                                     input logic ft, input logic ll,
                                     input logic [3:0] rt, input logic [7:0] ls);
    return {pr, sr, rd, ft, ll, rt, ls};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt, loss_cnt};
  endfunction

  function automatic logic [16:0] model_vec();
    return {(m_phase == PH_BOOT) || (m_phase == PH_STUCK), m_phase == PH_LIVE,
            m_phase == PH_LIVE, m_phase == PH_STUCK, m_lost, 4'(m_retries), 8'(m_losses)};
  endfunction

  function automatic void model_reset();
    m_phase   = PH_BOOT;
    m_elapsed = 0;
    m_retries = 0;
    m_losses  = 0;
    m_lost    = 1'b0;
    m_hist    = {};
    for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit lk;
    int prev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lk = m_hist.pop_front();
    m_hist.push_back(pll_locked);
    m_lost = 1'b0;
    prev = m_phase;
    m_elapsed++;
    case (m_phase)
      PH_BOOT:   if (m_elapsed == PRC) m_phase = PH_HUNT;
      PH_HUNT: begin
        if (lk) m_phase = PH_SETTLE;
        else if (m_elapsed == LT) begin
          if (m_retries == MR) m_phase = PH_STUCK;
          else begin
            m_retries++;
            m_phase = PH_BOOT;
          end
        end
      end
      PH_SETTLE: begin
        if (!lk) m_phase = PH_HUNT;
        else if (m_elapsed == SC) m_phase = PH_LIVE;
      end
      PH_LIVE: begin
        if (!lk) begin
          m_lost = 1'b1;
          if (m_losses < 255) m_losses++;
          m_retries = 0;
          m_phase = PH_BOOT;
        end
      end
      default: begin
        if (clear_fault) begin
          m_retries = 0;
          m_phase = PH_BOOT;
        end
      end
    endcase
    if (m_phase != prev) m_elapsed = 0;
  endfunction

  task automatic check_vec(input string name, input logic [16:0] got, input logic [16:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge=%0d t=%0t got=%h want=%h", name, edge_no, $time, got, want);
    end
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge=%0d t=%0t got=%0d want=%0d", name, edge_no, $time, got, want);
    end
  endtask

  // One clock: advance the model at the edge, then compare all outputs just after it.
  task automatic tick();
    @(posedge refclk);
    model_step();
    edge_no++;
    #1;
    check_vec("cycle_model", dut_vec(), model_vec());
  endtask

  task automatic tick_until(input int e);
    while (edge_no < e) tick();
  endtask

  task automatic async_reset_pulse(input string name, input int hold);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_vec(name, dut_vec(), RESET_VEC);
    repeat (hold) tick();
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic do_reset();
    pll_locked  = 1'b0;
    clear_fault = 1'b0;
    async_reset_pulse("reset_values", 3);
  endtask

  initial begin
    #3;
    do_reset();

    // Bring-up with lock rising at edge 10, then a lock drop in RUN and re-lock.
    tbl[0]  = '{3,  1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0)};
    tbl[1]  = '{1,  1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0)};
    tbl[2]  = '{6,  1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0)};
    tbl[3]  = '{10, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0)};
    tbl[4]  = '{1,  1'b1, 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0)};
    tbl[5]  = '{2,  1'b1, 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0)};
    tbl[6]  = '{2,  1'b0, 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0)};
    tbl[7]  = '{1,  1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1)};
    tbl[8]  = '{1,  1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1)};
    tbl[9]  = '{11, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1)};
    tbl[10] = '{1,  1'b1, 1'b0, mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1)};
    for (int i = 0; i < 11; i++) begin
      pll_locked  = tbl[i].lk;
      clear_fault = tbl[i].clr;
      repeat (tbl[i].cycles) tick();
      check_vec($sformatf("table_%0d", i), dut_vec(), tbl[i].exp);
    end

    // Lock never arrives: two retries, then FAULT, then clear_fault.
    do_reset();
    tick_until(23);
    check_val("s2_pre_timeout_pll_rst", 8'(pll_rst), 8'd0);
    tick_until(24);
    check_val("s2_retry1_pll_rst", 8'(pll_rst), 8'd1);
    check_val("s2_retry1_cnt", 8'(retry_cnt), 8'd1);
    tick_until(48);
    check_val("s2_retry2_cnt", 8'(retry_cnt), 8'd2);
    tick_until(71);
    check_val("s2_pre_fault", 8'(fault), 8'd0);
    tick_until(72);
    check_val("s2_fault", 8'(fault), 8'd1);
    check_val("s2_fault_pll_rst", 8'(pll_rst), 8'd1);
    tick_until(75);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_val("s2_clear_fault", 8'(fault), 8'd0);
    check_val("s2_clear_retry", 8'(retry_cnt), 8'd0);
    tick_until(79);
    check_val("s2_clear_pll_rst_held", 8'(pll_rst), 8'd1);
    tick();
    check_val("s2_clear_pll_rst_done", 8'(pll_rst), 8'd0);

    // One-cycle lock glitch during STABILIZE restarts qualification.
    do_reset();
    tick_until(6);
    pll_locked = 1'b1;
    tick_until(11);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick_until(17);
    check_val("s3_not_ready_early", 8'(ready), 8'd0);
    tick_until(22);
    check_val("s3_not_ready_yet", 8'(ready), 8'd0);
    tick();
    check_val("s3_ready", 8'(ready), 8'd1);
    check_val("s3_retry_unchanged", 8'(retry_cnt), 8'd0);

    // Lock arrives exactly at the last WAIT_LOCK cycle: lock wins.
    do_reset();
    tick_until(21);
    pll_locked = 1'b1;
    tick_until(24);
    check_val("s6_no_pll_rst", 8'(pll_rst), 8'd0);
    check_val("s6_retry", 8'(retry_cnt), 8'd0);
    tick_until(31);
    check_val("s6_not_ready", 8'(ready), 8'd0);
    tick();
    check_val("s6_ready", 8'(ready), 8'd1);

    // Async reset in STABILIZE, then in RUN after a lock loss.
    do_reset();
    tick_until(6);
    pll_locked = 1'b1;
    tick_until(11);
    async_reset_pulse("s5_reset_in_stabilize", 2);
    tick_until(13);
    check_val("s5_ready_after_reset", 8'(ready), 8'd1);
    pll_locked = 1'b0;
    tick_until(16);
    check_val("s5_loss_pulse", 8'(lock_lost), 8'd1);
    pll_locked = 1'b1;
    tick_until(30);
    check_val("s5_loss_cnt", 8'(loss_cnt), 8'd1);
    async_reset_pulse("s5_reset_in_run", 2);
    tick();
    check_val("s5_loss_cleared", 8'(loss_cnt), 8'd0);

    // Randomized lock behaviour with occasional clear_fault and reset pulses.
    do_reset();
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
        if (hold == 0) begin
          pll_locked = ~pll_locked;
          case ($urandom_range(0, 3))
            0:       hold = $urandom_range(1, 3);
            1:       hold = $urandom_range(4, 12);
            2:       hold = $urandom_range(15, 40);
            default: hold = $urandom_range(40, 120);
          endcase
        end else begin
          hold--;
        end
        clear_fault = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 599) == 0) async_reset_pulse("rand_reset", 2);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t run did not complete", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
